// File: rtl/i2c_pkg.sv
// Shared I2C definitions: state encoding, ACK/NACK levels and field widths.
// Usable by both the target (i2c_slave) and the bus controller (i2c_master).
package i2c_pkg;

  localparam int I2C_BYTE_W = 8;
  localparam int I2C_ADDR_W = 7;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    ADDR_ACK = 3'd2,
    RX_DATA  = 3'd3,
    RX_ACK   = 3'd4,
    TX_DATA  = 3'd5,
    TX_ACK   = 3'd6,
    IGNORE   = 3'd7
  } i2c_state_e;

  // True when the upper seven bits of a received address byte select this target.
  function automatic logic addr_match(input logic [I2C_BYTE_W-1:0] addr_byte,
                                      input logic [I2C_ADDR_W-1:0] own_addr);
    return (addr_byte[I2C_BYTE_W-1:1] == own_addr);
  endfunction

endpackage

// File: rtl/i2c_sync_edge.sv
// Multi-flop synchroniser with one history flop for edge detection.
// Flops preset to 1 so an idle (pulled-up) bus produces no edge out of reset.
module i2c_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;
  logic              hist_q;
  logic              hist_d;

  // Shift the raw input through the chain; history holds the previous synced value.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], din};
    hist_d = sync_q[STAGES-1];
  end

  // Synchroniser and history registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
      hist_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign dout = sync_q[STAGES-1];
  assign rise = sync_q[STAGES-1] & ~hist_q;
  assign fall = ~sync_q[STAGES-1] & hist_q;

endmodule

// File: rtl/i2c_slave.sv
// Single-address I2C target. Oversamples SCL/SDA on clk, decodes START/STOP,
// ACKs its address, delivers written bytes and returns bytes for reads.
// SDA is open-drain: only ever driven low, and only changed after an SCL fall.
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR  = 7'h50,
  parameter int                    SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i2c_scl,
  inout  wire                   i2c_sda,
  input  logic [I2C_BYTE_W-1:0] tx_data,
  output logic [I2C_BYTE_W-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  tx_load,
  output logic                  busy
);

  logic scl_s, scl_rise_s, scl_fall_s;
  logic sda_s, sda_rise_s, sda_fall_s;
  logic start_s, stop_s;
  logic sda_raw_s;

  i2c_state_e              state_q, state_d;
  logic [2:0]              cnt_q, cnt_d;
  logic [2:0]              cnt_dec_s;
  logic                    done_q, done_d;
  logic [I2C_BYTE_W-1:0]   shift_q, shift_d;
  logic [I2C_BYTE_W-1:0]   txbuf_q, txbuf_d;
  logic [I2C_BYTE_W-1:0]   rx_data_q, rx_data_d;
  logic                    rx_valid_q, rx_valid_d;
  logic                    tx_load_q, tx_load_d;
  logic                    sda_oe_q, sda_oe_d;
  logic                    busy_q, busy_d;

  assign sda_raw_s = i2c_sda;

  i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_scl_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (i2c_scl),
    .dout (scl_s),
    .rise (scl_rise_s),
    .fall (scl_fall_s)
  );

  i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_sda_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (sda_raw_s),
    .dout (sda_s),
    .rise (sda_rise_s),
    .fall (sda_fall_s)
  );

  assign start_s   = sda_fall_s & scl_s;
  assign stop_s    = sda_rise_s & scl_s;
  assign cnt_dec_s = cnt_q - 3'd1;

  // Next-state and output logic; STOP beats START beats SCL edges.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    done_d     = done_q;
    shift_d    = shift_q;
    txbuf_d    = txbuf_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_load_d  = 1'b0;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;

    if (stop_s) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_s) begin
      state_d  = ADDR;
      cnt_d    = 3'd7;
      done_d   = 1'b0;
      sda_oe_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          sda_oe_d = 1'b0;
          busy_d   = 1'b0;
        end

        ADDR, RX_DATA: begin
          if (scl_rise_s) begin
            shift_d = {shift_q[I2C_BYTE_W-2:0], sda_s};
            done_d  = (cnt_q == 3'd0);
            cnt_d   = cnt_dec_s;
          end else if (scl_fall_s && done_q) begin
            done_d = 1'b0;
            cnt_d  = 3'd7;
            if (state_q == ADDR) begin
              if (addr_match(shift_q, SLAVE_ADDR)) begin
                sda_oe_d = 1'b1;
                busy_d   = 1'b1;
                state_d  = ADDR_ACK;
              end else begin
                state_d = IGNORE;
              end
            end else begin
              rx_data_d  = shift_q;
              rx_valid_d = 1'b1;
              sda_oe_d   = 1'b1;
              state_d    = RX_ACK;
            end
          end else begin
            state_d = state_q;
          end
        end

        ADDR_ACK: begin
          if (scl_fall_s) begin
            cnt_d  = 3'd7;
            done_d = 1'b0;
            if (shift_q[0] == 1'b0) begin
              sda_oe_d = 1'b0;
              state_d  = RX_DATA;
            end else begin
              txbuf_d   = tx_data;
              tx_load_d = 1'b1;
              sda_oe_d  = ~tx_data[I2C_BYTE_W-1];
              state_d   = TX_DATA;
            end
          end else begin
            state_d = state_q;
          end
        end

        RX_ACK: begin
          if (scl_fall_s) begin
            sda_oe_d = 1'b0;
            cnt_d    = 3'd7;
            done_d   = 1'b0;
            state_d  = RX_DATA;
          end else begin
            state_d = state_q;
          end
        end

        TX_DATA: begin
          if (scl_fall_s) begin
            if (cnt_q == 3'd0) begin
              sda_oe_d = 1'b0;
              done_d   = 1'b0;
              state_d  = TX_ACK;
            end else begin
              cnt_d    = cnt_dec_s;
              sda_oe_d = ~txbuf_q[cnt_dec_s];
            end
          end else begin
            state_d = state_q;
          end
        end

        TX_ACK: begin
          if (scl_rise_s) begin
            if (sda_s == I2C_ACK) begin
              done_d = 1'b1;
            end else begin
              busy_d  = 1'b0;
              state_d = IGNORE;
            end
          end else if (scl_fall_s && done_q) begin
            txbuf_d   = tx_data;
            tx_load_d = 1'b1;
            sda_oe_d  = ~tx_data[I2C_BYTE_W-1];
            cnt_d     = 3'd7;
            done_d    = 1'b0;
            state_d   = TX_DATA;
          end else begin
            state_d = state_q;
          end
        end

        IGNORE: begin
          sda_oe_d = 1'b0;
          busy_d   = 1'b0;
        end

        default: begin
          state_d  = IDLE;
          sda_oe_d = 1'b0;
          busy_d   = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers; reset releases SDA immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd7;
      done_q     <= 1'b0;
      shift_q    <= 8'h00;
      txbuf_q    <= 8'h00;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      tx_load_q  <= 1'b0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      shift_q    <= shift_d;
      txbuf_q    <= txbuf_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_load_q  <= tx_load_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
    end
  end

  assign i2c_sda  = sda_oe_q ? 1'b0 : 1'bz;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign tx_load  = tx_load_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: a bit-level bus master drives SCL/SDA, and expected
// results come from transaction-level rules (address match -> ACK, written
// bytes appear on rx_data, read bytes equal the tx_data offered).
`timescale 1ns/1ps
module tb_i2c_slave;
  import i2c_pkg::*;

  localparam logic [6:0] OWN = 7'h50;
  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       m_sda = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic [7:0] rx_data;
  logic       rx_valid, tx_load, busy;
  wire        sda_bus;

  int n_total = 0;
  int n_pass  = 0;
  int rx_cnt = 0, tx_cnt = 0, both_cnt = 0;
  logic [7:0] rx_q[$];

  pullup (sda_bus);
  assign sda_bus = m_sda ? 1'bz : 1'b0;

  i2c_slave #(.SLAVE_ADDR(OWN), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .i2c_scl  (scl),
    .i2c_sda  (sda_bus),
    .tx_data  (tx_data),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_load  (tx_load),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Pulse monitor: counts every high cycle, so a stretched pulse shows up.
  always @(negedge clk) begin
    if (rx_valid) begin
      rx_cnt++;
      rx_q.push_back(rx_data);
    end
    if (tx_load) tx_cnt++;
    if (rx_valid && tx_load) both_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    else n_pass++;
  endtask

  // ---------------- bus master primitives ----------------
  task automatic q_wait(); repeat (Q) @(posedge clk); #1; endtask
  task automatic bus_start(); m_sda = 1'b1; q_wait(); scl = 1'b1; q_wait(); m_sda = 1'b0; q_wait(); scl = 1'b0; q_wait(); endtask
  task automatic bus_stop(); m_sda = 1'b0; q_wait(); scl = 1'b1; q_wait(); m_sda = 1'b1; q_wait(); endtask
  task automatic put_bit(input logic b); m_sda = b; q_wait(); scl = 1'b1; q_wait(); q_wait(); scl = 1'b0; q_wait(); endtask
  task automatic get_bit(output logic b); m_sda = 1'b1; q_wait(); scl = 1'b1; q_wait(); b = sda_bus; q_wait(); scl = 1'b0; q_wait(); endtask
  task automatic put_byte(input logic [7:0] v, output logic ack);
    for (int i = 7; i >= 0; i--) put_bit(v[i]);
    get_bit(ack);
  endtask
  task automatic get_byte(output logic [7:0] v);
    logic b;
    for (int i = 7; i >= 0; i--) begin get_bit(b); v[i] = b; end
  endtask

  // Reference rule: the target ACKs exactly its own 7-bit address.
  function automatic logic exp_ack(input logic [7:0] addr_byte);
    return (addr_byte[7:1] == OWN) ? I2C_ACK : I2C_NACK;
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (4) @(posedge clk); #1;
    chk("reset_rx_data", rx_data, 8'h00);
    chk("reset_rx_valid", rx_valid, 1'b0);
    chk("reset_tx_load", tx_load, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_sda_released", sda_bus, 1'b1);
    rst = 1'b0;
    repeat (4) @(posedge clk); #1;
  endtask

  task automatic test_write();
    logic ack; int rx0 = rx_cnt;
    bus_start();
    put_byte({OWN, 1'b0}, ack);
    chk("write_addr_ack", ack, I2C_ACK);
    chk("write_busy_high", busy, 1'b1);
    put_byte(8'hA5, ack);
    chk("write_data_ack", ack, I2C_ACK);
    bus_stop();
    chk("write_rx_data", rx_data, 8'hA5);
    chk("write_rx_pulses", rx_cnt - rx0, 1);
    chk("write_busy_low", busy, 1'b0);
  endtask

  task automatic test_wrong_addr();
    logic ack; int rx0 = rx_cnt;
    bus_start();
    put_byte({7'h51, 1'b0}, ack);
    chk("wrong_addr_nack", ack, I2C_NACK);
    chk("wrong_addr_busy", busy, 1'b0);
    bus_stop();
    chk("wrong_addr_rx_pulses", rx_cnt - rx0, 0);
  endtask

  task automatic test_read();
    logic ack; logic [7:0] v; int tx0 = tx_cnt;
    tx_data = 8'h3C;
    bus_start();
    put_byte({OWN, 1'b1}, ack);
    chk("read_addr_ack", ack, I2C_ACK);
    get_byte(v);
    chk("read_byte0", v, 8'h3C);
    tx_data = 8'hC3;
    put_bit(I2C_ACK);
    get_byte(v);
    chk("read_byte1", v, 8'hC3);
    put_bit(I2C_NACK);
    chk("read_tx_loads", tx_cnt - tx0, 2);
    m_sda = 1'b1; q_wait();
    chk("read_sda_released", sda_bus, 1'b1);
    chk("read_busy_after_nack", busy, 1'b0);
    bus_stop();
  endtask

  task automatic test_repeated_start();
    logic ack; logic [7:0] v; logic [7:0] t;
    t = 8'($urandom);
    bus_start();
    put_byte({OWN, 1'b0}, ack);
    chk("rs_wr_addr_ack", ack, I2C_ACK);
    put_byte(8'h11, ack);
    chk("rs_data_ack", ack, I2C_ACK);
    chk("rs_rx_data", rx_data, 8'h11);
    tx_data = t;
    bus_start();
    put_byte({OWN, 1'b1}, ack);
    chk("rs_rd_addr_ack", ack, I2C_ACK);
    get_byte(v);
    chk("rs_read_byte", v, t);
    put_bit(I2C_NACK);
    bus_stop();
  endtask

  task automatic test_reset_mid();
    logic ack;
    bus_start();
    put_byte({OWN, 1'b0}, ack);
    for (int i = 7; i >= 0; i--) put_bit(1'b1);
    m_sda = 1'b1; q_wait();
    chk("mid_slave_drives_ack", sda_bus, 1'b0);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("mid_sda_released_now", sda_bus, 1'b1);
    chk("mid_rx_data", rx_data, 8'h00);
    chk("mid_busy", busy, 1'b0);
    chk("mid_rx_valid", rx_valid, 1'b0);
    repeat (3) @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk); #1;
    bus_stop();
    bus_start();
    put_byte({OWN, 1'b0}, ack);
    chk("mid_recover_addr_ack", ack, I2C_ACK);
    put_byte(8'h7E, ack);
    chk("mid_recover_data_ack", ack, I2C_ACK);
    bus_stop();
    chk("mid_recover_rx_data", rx_data, 8'h7E);
  endtask

  task automatic test_stop_in_addr();
    logic b; int lows = 0; int rx0 = rx_cnt; int tx0 = tx_cnt;
    bus_start();
    put_bit(1'b1); put_bit(1'b0); put_bit(1'b1); put_bit(1'b0);
    bus_stop();
    chk("stopaddr_busy", busy, 1'b0);
    for (int i = 0; i < 9; i++) begin get_bit(b); if (b == 1'b0) lows++; end
    m_sda = 1'b1; scl = 1'b1; q_wait();
    chk("stopaddr_no_ack", lows, 0);
    chk("stopaddr_no_pulses", (rx_cnt - rx0) + (tx_cnt - tx0), 0);
  endtask

  task automatic test_random(input int n);
    logic ack; logic [7:0] v; logic [7:0] addr; int nb; int rx0; int tx0;
    logic [7:0] vals[3];
    for (int t = 0; t < n; t++) begin
      addr[7:1] = ($urandom_range(0, 1) == 0) ? OWN : 7'($urandom);
      if (addr[7:1] == OWN && $urandom_range(0, 3) == 0) addr[1] = ~addr[1];
      addr[0] = 1'($urandom);
      nb = $urandom_range(1, 3);
      for (int k = 0; k < 3; k++) vals[k] = 8'($urandom);
      rx_q.delete();
      rx0 = rx_cnt; tx0 = tx_cnt;
      tx_data = vals[0];
      bus_start();
      put_byte(addr, ack);
      chk("rand_addr_ack", ack, exp_ack(addr));
      if (exp_ack(addr) == I2C_ACK && addr[0] == 1'b0) begin
        for (int k = 0; k < nb; k++) begin
          put_byte(vals[k], ack);
          chk("rand_wr_ack", ack, I2C_ACK);
        end
        bus_stop();
        chk("rand_wr_count", rx_cnt - rx0, nb);
        for (int k = 0; k < nb; k++)
          chk("rand_wr_byte", (k < rx_q.size()) ? rx_q[k] : 8'hxx, vals[k]);
      end else if (exp_ack(addr) == I2C_ACK) begin
        for (int k = 0; k < nb; k++) begin
          get_byte(v);
          chk("rand_rd_byte", v, vals[k]);
          if (k < nb - 1) begin tx_data = vals[k + 1]; put_bit(I2C_ACK); end
          else put_bit(I2C_NACK);
        end
        bus_stop();
        chk("rand_rd_loads", tx_cnt - tx0, nb);
      end else begin
        bus_stop();
        chk("rand_nack_pulses", (rx_cnt - rx0) + (tx_cnt - tx0), 0);
      end
      chk("rand_busy_idle", busy, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_wrong_addr();
    test_read();
    test_repeated_start();
    test_reset_mid();
    test_stop_in_addr();
    test_random(8);
    chk("rx_valid_tx_load_overlap", both_cnt, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
